// File: rtl/usb_rx_pkt_engine.sv
// ---------------------------------------------------------------------------
// usb_rx_pkt_engine
//
// Parses the de-stuffed USB receive byte stream: SYNC, PID, then the token,
// data or handshake body of the packet.
// - DATA payload goes to the RX FIFO. The last two bytes are held back
//   because they are the CRC16 and must never reach the FIFO.
// - Tokens are filtered on device address and endpoint.
// - Protocol, CRC, overflow and bus-stall timeout problems are reported as
//   typed error codes.
//
// Ports
//   clk, n_rst          system clock, asynchronous active-low reset
//   rx_byte/_vld        received byte and its 1-cycle valid strobe
//   eop, eop_err        good / malformed end-of-packet strobes
//   bitstuff_err        bit-stuff violation strobe
//   crc5_ok, crc16_ok   CRC residue flags, looked at only together with eop
//   dev_addr            programmed device address
//   buf_occupancy       current RX FIFO fill level
//   buf_wdata/push      payload byte and FIFO write strobe (same cycle as
//                       the incoming byte that releases it)
//   buf_flush           discard the packet currently in the FIFO
//   crc_clear           restart the external CRC checkers
//   rx_busy             a packet is in progress
//   rx_pid/addr/endp/len  fields of the last accepted packet
//   pkt_done            packet accepted pulse
//   rx_error/err_code   sticky error flag and cause; cleared by the next SYNC
// ---------------------------------------------------------------------------
module usb_rx_pkt_engine #(
    parameter int MAX_PAYLOAD = 64,
    parameter int BUF_DEPTH   = 64,
    parameter int NUM_EP      = 4,
    parameter int TIMEOUT_CYC = 1024,
    localparam int OCC_W = $clog2(BUF_DEPTH + 1),
    localparam int LEN_W = $clog2(MAX_PAYLOAD + 1),
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic [7:0]       rx_byte,
    input  logic             rx_byte_vld,
    input  logic             eop,
    input  logic             eop_err,
    input  logic             bitstuff_err,
    input  logic             crc5_ok,
    input  logic             crc16_ok,
    input  logic [6:0]       dev_addr,
    input  logic [OCC_W-1:0] buf_occupancy,
    output logic [7:0]       buf_wdata,
    output logic             buf_push,
    output logic             buf_flush,
    output logic             crc_clear,
    output logic             rx_busy,
    output logic [3:0]       rx_pid,
    output logic [6:0]       rx_addr,
    output logic [3:0]       rx_endp,
    output logic [LEN_W-1:0] rx_len,
    output logic             pkt_done,
    output logic             rx_error,
    output logic [2:0]       err_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PID,
        S_TOKEN,
        S_DATA,
        S_HSK,
        S_ERR_WAIT
    } state_t;

    localparam logic [2:0] E_SYNC    = 3'd1;
    localparam logic [2:0] E_PIDCHK  = 3'd2;
    localparam logic [2:0] E_LEN     = 3'd3;
    localparam logic [2:0] E_LINE    = 3'd4;
    localparam logic [2:0] E_CRC     = 3'd5;
    localparam logic [2:0] E_OVF     = 3'd6;
    localparam logic [2:0] E_TIMEOUT = 3'd7;

    state_t state, state_nxt;

    logic [1:0]       tok_cnt;
    logic [7:0]       tok_b0;
    logic [2:0]       tok_b1;
    logic [1:0]       hold_cnt;
    logic [7:0]       hold1, hold0;
    logic [LEN_W-1:0] push_cnt;
    logic [3:0]       pid_q;
    logic [TO_W-1:0]  to_cnt;

    logic       err_det;
    logic [2:0] err_val;
    logic       flush_det;
    logic       done_det;
    logic       clr_det;
    logic       sync_ok;
    logic       pid_cap;
    logic       tok_cap;
    logic       data_shift;
    logic       push;
    logic       timed_out;
    logic [3:0] tok_endp;
    logic       tok_match;

    assign tok_endp  = {tok_b1, tok_b0[7]};
    assign tok_match = (tok_b0[6:0] == dev_addr) && ({28'd0, tok_endp} < 32'(NUM_EP));

    // A full stall window has elapsed only when nothing at all arrives this cycle.
    assign timed_out = (state != S_IDLE) && (to_cnt == TO_W'(TIMEOUT_CYC - 1))
                       && !rx_byte_vld && !eop && !bitstuff_err && !eop_err;

    assign rx_busy   = (state != S_IDLE);
    assign buf_push  = push;
    assign buf_wdata = hold1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Line errors outrank eop, which outranks a byte arriving in the same cycle.
    // Once in ERR_WAIT the first error of the packet is kept.
    always_comb begin
        state_nxt  = state;
        err_det    = 1'b0;
        err_val    = 3'd0;
        flush_det  = 1'b0;
        done_det   = 1'b0;
        clr_det    = 1'b0;
        sync_ok    = 1'b0;
        pid_cap    = 1'b0;
        tok_cap    = 1'b0;
        data_shift = 1'b0;
        push       = 1'b0;

        if (state == S_IDLE) begin
            if (rx_byte_vld) begin
                if (rx_byte == 8'h80) begin
                    sync_ok   = 1'b1;
                    state_nxt = S_PID;
                end else begin
                    err_det   = 1'b1;
                    err_val   = E_SYNC;
                    state_nxt = S_ERR_WAIT;
                end
            end
        end else if (bitstuff_err || eop_err) begin
            if (state != S_ERR_WAIT) begin
                err_det   = 1'b1;
                err_val   = E_LINE;
                flush_det = (state == S_DATA);
            end
            state_nxt = eop_err ? S_IDLE : S_ERR_WAIT;
        end else if (timed_out) begin
            if (state != S_ERR_WAIT) begin
                err_det   = 1'b1;
                err_val   = E_TIMEOUT;
                flush_det = (state == S_DATA);
            end
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_PID: begin
                    if (eop) begin
                        err_det   = 1'b1;
                        err_val   = E_LEN;
                        state_nxt = S_IDLE;
                    end else if (rx_byte_vld) begin
                        if (rx_byte[7:4] != ~rx_byte[3:0]) begin
                            err_det   = 1'b1;
                            err_val   = E_PIDCHK;
                            state_nxt = S_ERR_WAIT;
                        end else begin
                            case (rx_byte[3:0])
                                4'b0001, 4'b1001, 4'b1101: begin
                                    pid_cap   = 1'b1;
                                    clr_det   = 1'b1;
                                    state_nxt = S_TOKEN;
                                end
                                4'b0011, 4'b1011: begin
                                    pid_cap   = 1'b1;
                                    clr_det   = 1'b1;
                                    state_nxt = S_DATA;
                                end
                                4'b0010, 4'b1010, 4'b1110: begin
                                    pid_cap   = 1'b1;
                                    state_nxt = S_HSK;
                                end
                                default: begin
                                    err_det   = 1'b1;
                                    err_val   = E_LEN;
                                    state_nxt = S_ERR_WAIT;
                                end
                            endcase
                        end
                    end
                end
                S_TOKEN: begin
                    if (eop) begin
                        if (tok_cnt != 2'd2) begin
                            err_det = 1'b1;
                            err_val = E_LEN;
                        end else if (!crc5_ok) begin
                            err_det = 1'b1;
                            err_val = E_CRC;
                        end else if (tok_match) begin
                            done_det = 1'b1;
                        end
                        state_nxt = S_IDLE;
                    end else if (rx_byte_vld) begin
                        if (tok_cnt == 2'd2) begin
                            err_det   = 1'b1;
                            err_val   = E_LEN;
                            state_nxt = S_ERR_WAIT;
                        end else begin
                            tok_cap = 1'b1;
                        end
                    end
                end
                S_DATA: begin
                    if (eop) begin
                        if (hold_cnt != 2'd2) begin
                            err_det   = 1'b1;
                            err_val   = E_LEN;
                            flush_det = 1'b1;
                        end else if (!crc16_ok) begin
                            err_det   = 1'b1;
                            err_val   = E_CRC;
                            flush_det = 1'b1;
                        end else begin
                            done_det = 1'b1;
                        end
                        state_nxt = S_IDLE;
                    end else if (rx_byte_vld) begin
                        // With two bytes held, the older one is proven to be payload.
                        if (hold_cnt == 2'd2) begin
                            if ((buf_occupancy == OCC_W'(BUF_DEPTH)) ||
                                (push_cnt == LEN_W'(MAX_PAYLOAD))) begin
                                err_det   = 1'b1;
                                err_val   = E_OVF;
                                flush_det = 1'b1;
                                state_nxt = S_ERR_WAIT;
                            end else begin
                                push       = 1'b1;
                                data_shift = 1'b1;
                            end
                        end else begin
                            data_shift = 1'b1;
                        end
                    end
                end
                S_HSK: begin
                    if (eop) begin
                        done_det  = 1'b1;
                        state_nxt = S_IDLE;
                    end else if (rx_byte_vld) begin
                        err_det   = 1'b1;
                        err_val   = E_LEN;
                        state_nxt = S_ERR_WAIT;
                    end
                end
                S_ERR_WAIT: begin
                    if (eop) begin
                        state_nxt = S_IDLE;
                    end
                end
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Datapath: packet capture registers, registered status pulses and the
    // stall counter, which restarts on any bus activity or state change.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tok_cnt   <= '0;
            tok_b0    <= '0;
            tok_b1    <= '0;
            hold_cnt  <= '0;
            hold1     <= '0;
            hold0     <= '0;
            push_cnt  <= '0;
            pid_q     <= '0;
            to_cnt    <= '0;
            pkt_done  <= 1'b0;
            buf_flush <= 1'b0;
            crc_clear <= 1'b0;
            rx_error  <= 1'b0;
            err_code  <= '0;
            rx_pid    <= '0;
            rx_addr   <= '0;
            rx_endp   <= '0;
            rx_len    <= '0;
        end else begin
            pkt_done  <= done_det;
            buf_flush <= flush_det;
            crc_clear <= clr_det;

            if (sync_ok) begin
                rx_error <= 1'b0;
                err_code <= '0;
            end else if (err_det) begin
                rx_error <= 1'b1;
                err_code <= err_val;
            end

            if (pid_cap) begin
                pid_q    <= rx_byte[3:0];
                tok_cnt  <= '0;
                hold_cnt <= '0;
                push_cnt <= '0;
            end

            if (tok_cap) begin
                if (tok_cnt == 2'd0) begin
                    tok_b0 <= rx_byte;
                end else begin
                    tok_b1 <= rx_byte[2:0];
                end
                tok_cnt <= tok_cnt + 2'd1;
            end

            if (data_shift) begin
                hold1 <= hold0;
                hold0 <= rx_byte;
                if (hold_cnt != 2'd2) begin
                    hold_cnt <= hold_cnt + 2'd1;
                end
            end

            if (push) begin
                push_cnt <= push_cnt + LEN_W'(1);
            end

            if (done_det) begin
                rx_pid <= pid_q;
                if (state == S_TOKEN) begin
                    rx_addr <= tok_b0[6:0];
                    rx_endp <= tok_endp;
                end
                if (state == S_DATA) begin
                    rx_len <= push_cnt;
                end
            end

            if ((state == S_IDLE) || (state_nxt != state) || rx_byte_vld || eop) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + TO_W'(1);
            end
        end
    end

endmodule
